mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 32, byte-address width in bits.
REQ-003 Parameter DEPTH, default 64, word count of internal data memory; power of two, at least 2.
REQ-004 Parameter WAIT_CYCLES, default 3, added access latency; legal range 1..15.
REQ-005 Parameter BASE_ADDR, default 1024, byte address mapped to word 0.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 mem_r_en  input  1  load request from the EXE/MEM pipeline register.
REQ-009 mem_w_en  input  1  store request from the EXE/MEM pipeline register.
REQ-010 addr  input  ADDR_W  byte address (ALU result).
REQ-011 wdata  input  DATA_W  store data (Rm value).
REQ-012 rdata  output  DATA_W  load data, valid while done=1.
REQ-013 freeze  output  1  pipeline stall request; the upstream stages hold while 1.
REQ-014 done  output  1  one-cycle access-complete pulse.
REQ-015 err  output  1  access-fault pulse, coincident with done.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-017 IDLE with req=(mem_r_en|mem_w_en) SHALL latch addr, wdata and the operation, load the counter with WAIT_CYCLES-1, and go to WAIT; otherwise stay in IDLE.
REQ-018 WAIT SHALL decrement the counter each cycle and go to DONE on the cycle the counter reads 0.
REQ-019 DONE SHALL return to IDLE unconditionally, so a request still held in DONE is not re-issued.
REQ-020 freeze SHALL be combinational: 1 when (IDLE and req) or WAIT; 0 in DONE and in IDLE with no request.
REQ-021 A request first seen in cycle 0 SHALL produce freeze=1 for cycles 0..WAIT_CYCLES and done=1 in cycle WAIT_CYCLES+1.
REQ-022 Word index SHALL be ((addr - BASE_ADDR) >> 2) truncated to log2(DEPTH) bits.
REQ-023 A store SHALL write the latched wdata to the memory on the WAIT-to-DONE edge; a store writes nothing on any other edge.
REQ-024 A load SHALL register the memory word on the WAIT-to-DONE edge; rdata holds that value in DONE and holds its last value in every other cycle.
REQ-025 When mem_r_en and mem_w_en are both 1, the access SHALL be a store, and rdata SHALL be 0 in DONE.
REQ-026 Inputs changing while in WAIT or DONE SHALL have no effect, because the latched copy is used.
REQ-027 rdata for a store access SHALL be 0.

Reset
REQ-028 rst=1 SHALL force IDLE, counter=0, rdata=0, done=0 and err=0 on the next edge.
REQ-029 Reset asserted during WAIT SHALL abort the access: no memory write and no done pulse.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro MEM_STAGE_BOUNDS_CHECK_EN SHALL control the bounds check.
REQ-032 With MEM_STAGE_BOUNDS_CHECK_EN defined, the latched access is a fault when any of these holds: addr < BASE_ADDR, (addr-BASE_ADDR)>>2 >= DEPTH, or addr[1:0] != 0.
REQ-033 For a fault, err=1 in DONE, the store is suppressed, and rdata=0.
REQ-034 Without MEM_STAGE_BOUNDS_CHECK_EN, the index SHALL wrap modulo DEPTH per REQ-022, and err SHALL be constant 0.

Verification
REQ-035 Reset, then idle with no request -> freeze=0, done=0, err=0, rdata=0.
REQ-036 Store addr=1024, wdata=0xDEADBEEF at cycle 0 -> freeze=1 for cycles 0..3, done=1 at cycle 4; a later load of 1024 -> rdata=0xDEADBEEF at its done.
REQ-037 Store 0x11 to 1028 with the request held through DONE -> exactly one write and one done pulse; the FSM is in IDLE at cycle 5.
REQ-038 Both enables=1, addr=1032, wdata=0x55 -> the word at 1032 becomes 0x55, and rdata=0 in DONE.
REQ-039 rst=1 at cycle 2 of a store of 0x77 to 1036 -> IDLE at cycle 3, no done pulse, and a later load of 1036 returns the prior contents.
REQ-040 Load addr=1024+4*DEPTH -> with the macro: err=1, rdata=0; without the macro: err=0, rdata=word 0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: stalls the pipeline for WAIT_CYCLES, then stores/loads one word of a local RAM.
// Optional bounds/alignment fault detection is enabled by defining MEM_STAGE_BOUNDS_CHECK_EN.
module mem_stage_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              freeze,
    output logic              done,
    output logic              err
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [3:0]        CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              store_q, store_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic [ADDR_W-1:0] diff;
    logic [IDX_W-1:0]  idx;
    logic              fault;
    logic              finish;
    logic              mem_we;

    assign req    = mem_r_en | mem_w_en;
    assign diff   = addr_q - BASE;
    assign idx    = diff[IDX_W+1:2];
    assign finish = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we = finish && store_q && !fault;

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    assign fault = (addr_q < BASE) || (|diff[ADDR_W-1:IDX_W+2]) || (addr_q[1:0] != 2'b00);
`else
    // Out-of-range addresses simply wrap onto the RAM.
    logic unused_bits;
    assign unused_bits = ^{diff[1:0], diff[ADDR_W-1:IDX_W+2]};
    assign fault       = 1'b0;
`endif

    assign freeze = ((state_q == ST_IDLE) && req) || (state_q == ST_WAIT);
    assign rdata  = rdata_q;
    assign done   = done_q;
    assign err    = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        store_d = store_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                    addr_d  = addr;
                    wdata_d = wdata;
                    store_d = mem_w_en;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = fault;
                    rdata_d = (store_q || fault) ? '0 : mem[idx];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // DONE always falls back so a still-held request is not replayed.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; a reset edge only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule
